// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC local ejection/injection buffers.
//   NOC_FLIT_W    : default flit data width
//   NOC_PKT_FLITS : default flits per packet (also receive RAM depth)
//   NOC_ADDR_W    : default RAM address width (2**NOC_ADDR_W >= NOC_PKT_FLITS)
//   state_e       : packet FSM encoding, common to the injector side
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int NOC_FLIT_W    = 20;
    localparam int NOC_PKT_FLITS = 30;
    localparam int NOC_ADDR_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : noc_pkg

// File: rtl/datain_buf_ram.sv
// ---------------------------------------------------------------------------
// datain_buf_ram
// Simple dual-port RAM: one write port, one synchronous read port, read-first.
//   clk      : clock, both ports on posedge
//   rst_n    : asynchronous active-low reset of the read data register only
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : registered read data (1-cycle latency)
// The array holds 2**ADDR_W words so any address is in bounds; range
// limiting against the packet length is done by the caller.
// ---------------------------------------------------------------------------
module datain_buf_ram #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the same array gives read-first behaviour on a
    // same-address collision: the old word is returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule : datain_buf_ram

// File: rtl/datain_buf.sv
// ---------------------------------------------------------------------------
// datain_buf
// Receive-side packet sink for a NoC node's local ejection port. Captures a
// fixed-length packet of flits into RAM, accumulates a wrapping checksum and
// reports completion and protocol errors. Always ready (no back-pressure).
//   clk       : clock
//   RST       : asynchronous active-low reset
//   enable    : receive enable
//   clear     : synchronous return to IDLE, zeroes count/checksum/flags
//   datain    : incoming flit
//   in_valid  : datain valid this cycle
//   rd_addr   : readback address
//   rd_data   : readback data, registered; 0 for addresses past the packet
//   recv_cnt  : flits accepted so far
//   checksum  : sum of accepted flits modulo 2**FLIT_W
//   done      : full packet received
//   drop_err  : sticky, in_valid while enable low before the packet finished
//   ovf_err   : sticky, in_valid after the packet finished
// ---------------------------------------------------------------------------
module datain_buf
    import noc_pkg::*;
#(
    parameter int FLIT_W    = NOC_FLIT_W,
    parameter int PKT_FLITS = NOC_PKT_FLITS,
    parameter int ADDR_W    = NOC_ADDR_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              enable,
    input  logic              clear,
    input  logic [FLIT_W-1:0] datain,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [FLIT_W-1:0] rd_data,
    output logic [ADDR_W-1:0] recv_cnt,
    output logic [FLIT_W-1:0] checksum,
    output logic              done,
    output logic              drop_err,
    output logic              ovf_err
);

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
    logic [ADDR_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [FLIT_W-1:0]   checksum_q, checksum_d;
    logic                done_q,     done_d;
    logic                drop_err_q, drop_err_d;
    logic                ovf_err_q,  ovf_err_d;
    logic                rd_oor_q,   rd_oor_d;

    logic                accept;
    logic [FLIT_W-1:0]   ram_rd_data;

    // clear wins over everything, so a flit presented with it is never written.
    assign accept = in_valid && enable && (state_q != ST_DONE) && !clear;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        recv_cnt_d = recv_cnt_q;
        checksum_d = checksum_q;
        done_d     = done_q;
        drop_err_d = drop_err_q;
        ovf_err_d  = ovf_err_q;

        if (clear) begin
            state_d    = ST_IDLE;
            wr_addr_d  = '0;
            recv_cnt_d = '0;
            checksum_d = '0;
            done_d     = 1'b0;
            drop_err_d = 1'b0;
            ovf_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_RECV: begin
                    if (accept) begin
                        recv_cnt_d = recv_cnt_q + ADDR_W'(1);
                        checksum_d = checksum_q + datain;
                        // Covers the single-flit packet too: IDLE goes
                        // straight to DONE when the last address is 0.
                        if (wr_addr_q == ADDR_W'(PKT_FLITS - 1)) begin
                            state_d   = ST_DONE;
                            wr_addr_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            state_d   = ST_RECV;
                            wr_addr_d = wr_addr_q + ADDR_W'(1);
                        end
                    end else if (in_valid && !enable) begin
                        drop_err_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (in_valid) begin
                        ovf_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Remember whether the address being read lies past the packet so the
    // RAM word can be masked in the same cycle it appears.
    always_comb begin
        rd_oor_d = (int'(rd_addr) >= PKT_FLITS);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            recv_cnt_q <= '0;
            checksum_q <= '0;
            done_q     <= 1'b0;
            drop_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            recv_cnt_q <= recv_cnt_d;
            checksum_q <= checksum_d;
            done_q     <= done_d;
            drop_err_q <= drop_err_d;
            ovf_err_q  <= ovf_err_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    datain_buf_ram #(
        .DATA_W (FLIT_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (RST),
        .we      (accept),
        .wr_addr (wr_addr_q),
        .wr_data (datain),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    assign rd_data  = rd_oor_q ? '0 : ram_rd_data;
    assign recv_cnt = recv_cnt_q;
    assign checksum = checksum_q;
    assign done     = done_q;
    assign drop_err = drop_err_q;
    assign ovf_err  = ovf_err_q;

endmodule : datain_buf

// File: tb/tb_datain_buf.sv
// ---------------------------------------------------------------------------
// tb_datain_buf
// Drives directed packet scenarios followed by random traffic into datain_buf
// and compares every cycle against a packet-level reference model (flit
// count, running sum, stored words, sticky error bits).
// ---------------------------------------------------------------------------
module tb_datain_buf;
    import noc_pkg::*;

    localparam int FW = NOC_FLIT_W;
    localparam int PK = NOC_PKT_FLITS;
    localparam int AW = NOC_ADDR_W;
    localparam logic [FW-1:0] FMASK = '1;

    logic          clk;
    logic          RST;
    logic          enable;
    logic          clear;
    logic [FW-1:0] datain;
    logic          in_valid;
    logic [AW-1:0] rd_addr;
    logic [FW-1:0] rd_data;
    logic [AW-1:0] recv_cnt;
    logic [FW-1:0] checksum;
    logic          done;
    logic          drop_err;
    logic          ovf_err;

    datain_buf dut (
        .clk      (clk),
        .RST      (RST),
        .enable   (enable),
        .clear    (clear),
        .datain   (datain),
        .in_valid (in_valid),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .recv_cnt (recv_cnt),
        .checksum (checksum),
        .done     (done),
        .drop_err (drop_err),
        .ovf_err  (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the packet is a list of stored flits; everything
    // else follows from how many have been kept.
    logic [FW-1:0] ram_m [PK];
    bit            known_m [PK];
    int            cnt_m;
    longint        sum_m;
    bit            drop_m;
    bit            ovf_m;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("recv_cnt", 32'(recv_cnt), 32'(cnt_m));
        chk("checksum", 32'(checksum), 32'(sum_m % (longint'(1) << FW)));
        chk("done",     32'(done),     32'(cnt_m == PK));
        chk("drop_err", 32'(drop_err), 32'(drop_m));
        chk("ovf_err",  32'(ovf_err),  32'(ovf_m));
    endtask

    // One clock cycle of stimulus; outputs sampled 1 time unit after the edge.
    task automatic step(input bit v, input bit en, input bit clr,
                        input logic [FW-1:0] d, input logic [AW-1:0] ra);
        logic [FW-1:0] exp_rd;
        bit            rd_known;
        in_valid = v;
        enable   = en;
        clear    = clr;
        datain   = d;
        rd_addr  = ra;
        // Read sees the RAM before this cycle's write.
        if (int'(ra) >= PK) begin
            exp_rd   = '0;
            rd_known = 1'b1;
        end else begin
            exp_rd   = ram_m[int'(ra)];
            rd_known = known_m[int'(ra)];
        end
        if (clr) begin
            cnt_m  = 0;
            sum_m  = 0;
            drop_m = 1'b0;
            ovf_m  = 1'b0;
        end else if (cnt_m == PK) begin
            if (v) ovf_m = 1'b1;
        end else if (v && en) begin
            ram_m[cnt_m]   = d;
            known_m[cnt_m] = 1'b1;
            cnt_m          = cnt_m + 1;
            sum_m          = sum_m + longint'(d);
        end else if (v) begin
            drop_m = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_state();
        if (rd_known) chk("rd_data", 32'(rd_data), 32'(exp_rd));
        $display("cyc=%0d v=%0b en=%0b clr=%0b d=%05h ra=%0d | cnt=%0d cs=%05h done=%0b drop=%0b ovf=%0b rd=%05h",
                 cyc, v, en, clr, d, ra, recv_cnt, checksum, done, drop_err, ovf_err, rd_data);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        in_valid = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        #2;
        RST = 1'b0;
        cnt_m  = 0;
        sum_m  = 0;
        drop_m = 1'b0;
        ovf_m  = 1'b0;
        #1;
        check_state();
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        $display("reset asserted t=%0t cnt=%0d cs=%05h done=%0b", $time, recv_cnt, checksum, done);
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b1;
    endtask

    task automatic send_pkt(input bit gaps);
        for (int k = 0; k < PK; k++) begin
            step(1'b1, 1'b1, 1'b0, FW'(k + 1), AW'($urandom_range(0, 31)));
            if (gaps) step(1'b0, 1'b1, 1'b0, FW'($urandom), AW'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        RST      = 1'b0;
        in_valid = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        datain   = '0;
        rd_addr  = '0;
        cnt_m    = 0;
        sum_m    = 0;
        drop_m   = 1'b0;
        ovf_m    = 1'b0;
        for (int i = 0; i < PK; i++) begin
            ram_m[i]   = '0;
            known_m[i] = 1'b0;
        end
        #3;
        do_reset();

        // 1: back-to-back packet, then read every address (incl. out of range)
        send_pkt(1'b0);
        chk("t1_checksum", 32'(checksum), 32'h001D1);
        chk("t1_cnt", 32'(recv_cnt), 32'd30);
        for (int a = 0; a < 32; a++) step(1'b0, 1'b1, 1'b0, '0, AW'(a));

        // 2: same packet with a gap every other cycle
        step(1'b0, 1'b1, 1'b1, '0, '0);
        send_pkt(1'b1);
        chk("t2_checksum", 32'(checksum), 32'h001D1);
        chk("t2_done", 32'(done), 32'd1);

        // 3: enable dropped for 3 presented flits
        step(1'b0, 1'b1, 1'b1, '0, '0);
        for (int k = 0; k < PK; k++) begin
            step(1'b1, !(k >= 10 && k < 13), 1'b0, FW'(k + 1), AW'($urandom_range(0, 31)));
        end
        chk("t3_cnt", 32'(recv_cnt), 32'd27);
        chk("t3_drop", 32'(drop_err), 32'd1);
        chk("t3_done", 32'(done), 32'd0);

        // 4: overflow after done, then clear
        step(1'b0, 1'b1, 1'b1, '0, '0);
        send_pkt(1'b0);
        step(1'b1, 1'b1, 1'b0, 20'hFFFFF, 5'd0);
        step(1'b1, 1'b0, 1'b0, 20'hFFFFF, 5'd29);
        chk("t4_ovf", 32'(ovf_err), 32'd1);
        chk("t4_checksum", 32'(checksum), 32'h001D1);
        step(1'b0, 1'b1, 1'b1, '0, '0);
        chk("t4_clr_cnt", 32'(recv_cnt), 32'd0);

        // 5: checksum wrap, then clear coincident with a valid flit
        step(1'b1, 1'b1, 1'b0, 20'hFFFFF, '0);
        step(1'b1, 1'b1, 1'b0, 20'h00002, '0);
        for (int k = 0; k < PK - 2; k++) step(1'b1, 1'b1, 1'b0, '0, AW'(k));
        chk("t5_checksum", 32'(checksum), 32'h00001);
        step(1'b1, 1'b1, 1'b1, 20'h00007, '0);
        chk("t5_clr_cnt", 32'(recv_cnt), 32'd0);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        chk("t5_addr0", 32'(rd_data), 32'h00000FFFFF);

        // 6: reset mid-packet, then a clean packet
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, FW'($urandom), AW'(k));
        do_reset();
        send_pkt(1'b0);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_checksum", 32'(checksum), 32'h001D1);

        // 7: random traffic
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 39) == 0), FW'($urandom), AW'($urandom_range(0, 31)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_datain_buf
